// File: rtl/pwm_capture_pkg.sv
// Shared constants and types for the PWM input-capture peripheral:
// register addresses, CTRL/STATUS bit positions, FSM states and the
// TIMEOUT reset value.
package pwm_capture_pkg;

    // Register addresses
    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_STATUS  = 4'h1;
    localparam logic [3:0] ADDR_PERIOD  = 4'h2;
    localparam logic [3:0] ADDR_HIGH    = 4'h3;
    localparam logic [3:0] ADDR_TIMEOUT = 4'h4;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_INVERT = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int ST_VALID = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_TOUT  = 2;
    localparam int ST_LEVEL = 3;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        HIGH_PH = 2'd2,
        LOW_PH  = 2'd3
    } state_t;

    // TIMEOUT resets to all-ones; the top slices this to its own width.
    localparam logic [63:0] TIMEOUT_RST = '1;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizes the asynchronous PWM input through a flop chain, applies the
// optional inversion and produces single-cycle rise/fall pulses.
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    input  logic invert,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;

    // Shift the raw input through the synchronizer and remember the last level.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            level_q <= level;
        end
    end

    assign level = sync_q[SYNC_STAGES-1] ^ invert;
    assign rise  = level & ~level_q;
    assign fall  = ~level & level_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input-capture peripheral. Measures period and high time of an external
// PWM signal in clk cycles, with overflow and loss-of-signal detection, a
// coherent PERIOD/HIGH read pair and a level interrupt.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    input  logic             pwm_in,
    output logic             irq
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Control / status registers
    logic             en, invert, irq_en;
    logic             valid, ovf, tout;
    logic [WIDTH-1:0] timeout_reg;

    // Measurement state
    state_t           state;
    logic [WIDTH-1:0] cnt;          // cycles since the last rising edge
    logic [WIDTH-1:0] idle_cnt;     // cycles since the last edge of either kind
    logic [WIDTH-1:0] high_lat;     // high time of the period in progress
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_live;
    logic [WIDTH-1:0] high_shadow;

    // Synchronized input
    logic level, rise, fall;

    // Decoded events
    logic             measuring, edge_any;
    logic             period_done, ovf_hit, tout_hit;
    logic             wr_ctrl, wr_status, wr_timeout, rd_period;
    logic [WIDTH-1:0] rd_mux;

    pwm_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .invert(invert),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Decode register strobes and the measurement events of this cycle.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ctrl     = wr_en && (addr == ADDR_CTRL);
        wr_status   = wr_en && (addr == ADDR_STATUS);
        wr_timeout  = wr_en && (addr == ADDR_TIMEOUT);
        rd_period   = rd_en && (addr == ADDR_PERIOD);
        measuring   = en && ((state == HIGH_PH) || (state == LOW_PH));
        edge_any    = rise || fall;
        period_done = en && (state == LOW_PH) && rise;
        ovf_hit     = measuring && (cnt == CNT_MAX) && !period_done;
        tout_hit    = en && (state != IDLE) && (timeout_reg != '0) &&
                      (idle_cnt >= timeout_reg) && !edge_any;
    end

    // Measurement FSM with the period/high counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idle_cnt  <= '0;
            high_lat  <= '0;
            period    <= '0;
            high_live <= '0;
        end else if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            idle_cnt <= '0;
        end else if (state == IDLE) begin
            state    <= ARM;
            cnt      <= '0;
            idle_cnt <= '0;
        end else begin
            if (edge_any)
                idle_cnt <= ONE;
            else if (idle_cnt != CNT_MAX)
                idle_cnt <= idle_cnt + ONE;

            if (tout_hit || ovf_hit) begin
                // Abandon the measurement; only a timeout clears the results.
                state <= ARM;
                cnt   <= '0;
                if (tout_hit) begin
                    idle_cnt  <= '0;
                    period    <= '0;
                    high_live <= '0;
                end
            end else begin
                unique case (state)
                    ARM: begin
                        if (rise) begin
                            state <= HIGH_PH;
                            cnt   <= ONE;
                        end
                    end
                    HIGH_PH: begin
                        cnt <= cnt + ONE;
                        if (fall) begin
                            high_lat <= cnt;
                            state    <= LOW_PH;
                        end
                    end
                    LOW_PH: begin
                        if (rise) begin
                            period    <= cnt;
                            high_live <= high_lat;
                            cnt       <= ONE;
                            state     <= HIGH_PH;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // CTRL and TIMEOUT register writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en          <= 1'b0;
            invert      <= 1'b0;
            irq_en      <= 1'b0;
            timeout_reg <= TIMEOUT_RST[WIDTH-1:0];
        end else begin
            if (wr_ctrl) begin
                en     <= wr_data[CTRL_EN];
                invert <= wr_data[CTRL_INVERT];
                irq_en <= wr_data[CTRL_IRQ_EN];
            end
            if (wr_timeout)
                timeout_reg <= wr_data;
        end
    end

    // Sticky STATUS flags: hardware set wins over a write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ovf   <= 1'b0;
            tout  <= 1'b0;
        end else begin
            valid <= period_done | (valid & ~(wr_status & wr_data[ST_VALID]));
            ovf   <= ovf_hit     | (ovf   & ~(wr_status & wr_data[ST_OVF]));
            tout  <= tout_hit    | (tout  & ~(wr_status & wr_data[ST_TOUT]));
        end
    end

    // Snapshot the live HIGH value whenever PERIOD is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            high_shadow <= '0;
        else if (rd_period)
            high_shadow <= high_live;
    end

    // Read multiplexer; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        unique case (addr)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN]     = en;
                rd_mux[CTRL_INVERT] = invert;
                rd_mux[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_STATUS: begin
                rd_mux[ST_VALID] = valid;
                rd_mux[ST_OVF]   = ovf;
                rd_mux[ST_TOUT]  = tout;
                rd_mux[ST_LEVEL] = level;
            end
            ADDR_PERIOD:  rd_mux = period;
            ADDR_HIGH:    rd_mux = high_shadow;
            ADDR_TIMEOUT: rd_mux = timeout_reg;
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            irq     <= 1'b0;
        end else begin
            if (rd_en)
                rd_data <= rd_mux;
            irq <= irq_en & (valid | ovf | tout);
        end
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM input-capture peripheral: the receive-side counterpart of the PWM generator. Samples an external PWM waveform on the system clock and measures its period and high time in `clk` cycles. Reports results through the same 4-bit-address register interface used by the PWM generator. Flags overflow and loss-of-signal, and raises a level interrupt.

## Interface
- `WIDTH`, 16: width of the measurement counters and the register data bus.
- `SYNC_STAGES`, 2: synchronizer depth on `pwm_in`; minimum 2.
- `clk`  in  1: system clock; all logic runs on it.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wr_en`  in  1: register write strobe.
- `rd_en`  in  1: register read strobe.
- `addr`  in  4: register address.
- `wr_data`  in  WIDTH: write data.
- `rd_data`  out  WIDTH: read data, registered.
- `pwm_in`  in  1: asynchronous PWM input.
- `irq`  out  1: level interrupt, registered.

## Operation
- Register map; unmapped addresses read 0 and ignore writes:
  - 0x0 CTRL, RW, reset 0: bit0 `en`, bit1 `invert` (measure active-low pulses), bit2 `irq_en`.
  - 0x1 STATUS: bit0 `valid`, bit1 `ovf`, bit2 `tout` (all sticky, write-1-to-clear); bit3 `level` (synchronized input after invert, RO).
  - 0x2 PERIOD, RO, reset 0: last complete period.
  - 0x3 HIGH, RO, reset 0: high time, taken from the shadow copy.
  - 0x4 TIMEOUT, RW, reset all-ones: loss-of-signal limit in cycles; 0 disables it.
- Coherent pair read:
  - Reading PERIOD copies the live HIGH value into a shadow register in the same cycle.
  - Reading HIGH returns the shadow, so a PERIOD-then-HIGH read sequence always yields a matched pair.
- `pwm_in` is synchronized through `SYNC_STAGES` flops, XORed with `invert`, then edge-detected.
- FSM:
  - IDLE: entered whenever `en`=0.
  - IDLE → ARM when `en`=1.
  - ARM → HIGH_PH on a rising edge. The partial first cycle is discarded and the counter restarts.
  - HIGH_PH → LOW_PH on a falling edge. The high count is latched internally.
  - LOW_PH → HIGH_PH on a rising edge. In that cycle PERIOD and live HIGH update together, `valid` sets, and the counter restarts.
- Measurement contract: an input that is high H cycles and low L cycles yields PERIOD = H+L and HIGH = H, both ≥1.
- Counter rules:
  - Increments every cycle in HIGH_PH/LOW_PH and saturates at 2^WIDTH−1.
  - Reaching saturation sets `ovf`, moves the FSM to ARM, and leaves PERIOD/HIGH unchanged.
- Timeout: if the cycles since the last edge reach TIMEOUT (nonzero) in ARM/HIGH_PH/LOW_PH:
  - `tout` sets;
  - PERIOD ← 0 and HIGH ← 0;
  - the FSM goes to ARM. A constant input is therefore reported as 0/0, with `level` giving 0% or 100%.
- Simultaneous events:
  - Timeout and overflow in the same cycle set both flags.
  - A hardware set and a W1C of the same bit in the same cycle: set wins.
  - A period completing in the same cycle as a PERIOD read: the read returns the old value; the shadow takes the old HIGH.
- Disable mid-measurement (`en`←0): FSM returns to IDLE the next cycle. Counter clears; PERIOD/HIGH/STATUS are held.
- `irq` = registered `irq_en` & (`valid` | `ovf` | `tout`).
- Write to a RO register or RO bit: ignored. `wr_en` and `rd_en` in the same cycle: both act; the read returns the pre-write value.

## Timing
- `rd_data` is valid one cycle after `rd_en`, and holds its last value when `rd_en`=0. Reset value 0.
- Writes take effect at the clock edge where `wr_en`=1.
- Input-to-detection latency: an edge on `pwm_in` is seen `SYNC_STAGES`+1 cycles later.
- PERIOD/HIGH/`valid` update in the detection cycle; `irq` asserts one cycle after that.
- Reset values:
  - `rd_data`=0, `irq`=0;
  - all registers as listed above;
  - FSM=IDLE, synchronizer flops=0.
- Async reset mid-measurement: everything returns to reset values immediately; no partial result is kept.

## Structure
- Package `pwm_capture_pkg` holds:
  - register address constants;
  - CTRL/STATUS bit indices;
  - FSM state enum (IDLE, ARM, HIGH_PH, LOW_PH);
  - TIMEOUT reset constant.
- Sub-module `pwm_in_sync`: N-flop synchronizer plus invert and rise/fall edge pulses.
- Register file, FSM and counter stay in the top module.

## Test plan
- Enable, CTRL=0x1; drive high 30 / low 70 repeatedly → after the second rising edge PERIOD=100, HIGH=30, STATUS bit0=1.
- Same waveform with CTRL=0x3 (invert) → PERIOD=100, HIGH=70; with `irq_en` set, `irq`=1 one cycle after `valid`. W1C STATUS=0x1 → `irq`=0 the next cycle.
- TIMEOUT=50; hold `pwm_in`=1 for 200 cycles after a valid measurement → `tout`=1, PERIOD=0, HIGH=0, `level`=1.
- WIDTH=8, TIMEOUT=0; high 300 cycles → `ovf`=1, PERIOD/HIGH unchanged, FSM back in ARM; next clean 10/10 waveform → PERIOD=20, HIGH=10.
- Read PERIOD, then a new measurement completes (40/60), then read HIGH → the HIGH read returns the shadow matching the earlier PERIOD, not 40.
- Deassert `en` mid-HIGH_PH, then pulse `rst_n` low during LOW_PH → registers held after disable; all outputs and registers return to reset values immediately on reset.
